// File: rtl/denormalize_pkg.sv
// Shared definitions for the sequential denormalizer: FSM state encoding and
// the shift-count width helper.
package denormalize_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Wide enough to hold DATA_W itself, which is the clamped maximum shift.
    function automatic int cnt_w(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

endpackage

// File: rtl/denormalize_seq.sv
// Right-shifts a left-justified vector back by its normalization count, one
// bit per cycle, collecting the shifted-out bits into a sticky flag.
module denormalize_seq
    import denormalize_pkg::*;
#(
    parameter  int DATA_W = 8,
    localparam int CNT_W  = cnt_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_vector,
    input  logic [CNT_W-1:0]  in_cnt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out,
    output logic              out_sticky
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DATA_W);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              sticky_q, sticky_d;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d  = state_q;
        data_d   = data_q;
        rem_d    = rem_q;
        sticky_d = sticky_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    data_d   = in_vector;
                    sticky_d = 1'b0;
                    rem_d    = (in_cnt >= MAX_CNT) ? MAX_CNT : in_cnt;
                    state_d  = (rem_d == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d   = data_q >> 1;
                sticky_d = sticky_q | data_q[0];
                rem_d    = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;  // unused encoding 2'd3 falls back to IDLE
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            data_q   <= '0;
            rem_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            rem_q    <= rem_d;
            sticky_q <= sticky_d;
        end
    end

    // Handshake outputs depend only on registered state.
    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out        = data_q;
    assign out_sticky = sticky_q;

endmodule

// File: tb/tb_denormalize_seq.sv
// Self-checking bench for denormalize_seq: a shift/sticky reference model with
// a per-cycle scoreboard monitor, plus directed vectors with literal results.
module tb_denormalize_seq;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_vector;
    logic [CW-1:0] in_cnt;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out;
    logic          out_sticky;

    denormalize_seq #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vector (in_vector),
        .in_cnt    (in_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_sticky(out_sticky)
    );

    typedef struct {
        logic [W-1:0] exp_out;
        logic         exp_stk;
        int           n;
        int           hs;
    } sb_t;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         hs_cyc = 0;
    int         out_hs = 0;
    bit         rand_mode = 0;
    bit         ready_fixed = 1;
    sb_t        sb[$];
    logic [W-1:0] rt_q[$];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: out = v >> min(c, W); sticky = OR of the low min(c, W) bits of v.
    function automatic sb_t model(input logic [W-1:0] v, input logic [CW-1:0] c, input int hs);
        sb_t m;
        int  k;
        int  mask;
        k         = (c >= W) ? W : int'(c);
        mask      = (1 << k) - 1;
        m.exp_out = v >> k;
        m.exp_stk = |(32'(v) & mask);
        m.n       = k;
        m.hs      = hs;
        return m;
    endfunction

    // Single driver of out_ready: fixed level or random per cycle.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
        end
    end

    // Monitor: scoreboard push on input handshake, full compare every cycle out_valid is high.
    initial begin
        bit prev_valid = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                rt_q.delete();
                prev_valid = 0;
            end else begin
                check("valid_ready_excl", 32'(out_valid & in_ready), 0);
                if (in_valid && in_ready)
                    sb.push_back(model(in_vector, in_cnt, cyc));
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out_valid", 32'(out_valid), 0);
                    end else begin
                        if (!prev_valid)
                            check("mon_latency", 32'(cyc - sb[0].hs - 1), 32'(sb[0].n));
                        check("mon_out", 32'(out), 32'(sb[0].exp_out));
                        check("mon_sticky", 32'(out_sticky), 32'(sb[0].exp_stk));
                        if (out_ready) begin
                            if (rt_q.size() > 0) begin
                                check("roundtrip_out", 32'(out), 32'(rt_q[0]));
                                check("roundtrip_sticky", 32'(out_sticky), 0);
                                void'(rt_q.pop_front());
                            end
                            void'(sb.pop_front());
                            out_hs++;
                        end
                    end
                end
                prev_valid = out_valid && !out_ready;
            end
        end
    end

    task automatic send(input logic [W-1:0] v, input logic [CW-1:0] c);
        int n = 0;
        in_vector = v;
        in_cnt    = c;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 1);
        hs_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        ok = 0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("out_timeout", 32'(out_valid), 1);
    endtask

    task automatic run_dir(input string name, input logic [W-1:0] v, input logic [CW-1:0] c,
                           input logic [W-1:0] exp_out, input logic exp_stk, input int exp_lat);
        bit ok;
        send(v, c);
        wait_out(ok);
        if (ok) begin
            check({name, "_out"}, 32'(out), 32'(exp_out));
            check({name, "_sticky"}, 32'(out_sticky), 32'(exp_stk));
            check({name, "_latency"}, 32'(cyc - hs_cyc - 1), 32'(exp_lat));
            @(negedge clk);
            check({name, "_in_ready_after"}, 32'(in_ready), 1);
            check({name, "_out_valid_after"}, 32'(out_valid), 0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        int hs0;
        int lz;
        logic [W-1:0] nv;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vector = '0;
        in_cnt    = '0;
        #1;
        check("reset_out", 32'(out), 0);
        check("reset_sticky", 32'(out_sticky), 0);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_dir("t1_b4_3", 8'hB4, 4'd3, 8'h16, 1'b1, 3);
        run_dir("t2_81_0", 8'h81, 4'd0, 8'h81, 1'b0, 0);
        run_dir("t3_01_8", 8'h01, 4'd8, 8'h00, 1'b1, 8);
        run_dir("t3_80_f", 8'h80, 4'hF, 8'h00, 1'b1, 8);
        run_dir("t_zero_5", 8'h00, 4'd5, 8'h00, 1'b0, 5);
        run_dir("t6_d0_4", 8'hD0, 4'd4, 8'h0D, 1'b0, 4);

        // Backpressure in DONE with an ignored in_valid pulse.
        ready_fixed = 0;
        send(8'hF0, 4'd2);
        wait_out(ok);
        if (ok) begin
            check("t4_out", 32'(out), 32'h3C);
            check("t4_latency", 32'(cyc - hs_cyc - 1), 2);
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check("t4_hold_out", 32'(out), 32'h3C);
                check("t4_hold_sticky", 32'(out_sticky), 0);
                check("t4_hold_valid", 32'(out_valid), 1);
                check("t4_hold_in_ready", 32'(in_ready), 0);
                if (i == 1) begin
                    #1;
                    in_vector = 8'hAA;
                    in_cnt    = 4'd1;
                    in_valid  = 1'b1;
                end else if (i == 2) begin
                    #1;
                    in_valid = 1'b0;
                end
            end
        end
        hs0 = out_hs;
        ready_fixed = 1;
        repeat (6) @(negedge clk);
        check("t4_one_handshake", 32'(out_hs - hs0), 1);
        check("t4_idle_after", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        // Reset in the middle of SHIFT.
        send(8'hFF, 4'd6);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_shift_rst_valid", 32'(out_valid), 0);
        check("t5_shift_rst_ready", 32'(in_ready), 1);
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_dir("t5_40_1", 8'h40, 4'd1, 8'h20, 1'b0, 1);

        // Reset while a result is held in DONE.
        ready_fixed = 0;
        send(8'h55, 4'd1);
        wait_out(ok);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_done_rst_valid", 32'(out_valid), 0);
        check("t5_done_rst_ready", 32'(in_ready), 1);
        check("t5_done_rst_out", 32'(out), 0);
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        ready_fixed = 1;
        @(posedge clk);
        #1;
        repeat (3) @(negedge clk);
        check("t5_no_stale_output", 32'(out_valid), 0);
        @(posedge clk);
        #1;

        // Round trip through a leading-zero normalizer for every vector.
        hs0 = out_hs;
        rand_mode = 1;
        for (int v = 0; v < 256; v++) begin
            lz = 0;
            while (lz < W && v[W-1-lz] == 1'b0) lz++;
            nv = W'(v << lz);
            rt_q.push_back(W'(v));
            send(nv, CW'(lz));
        end
        for (int n = 0; n < 200 && sb.size() > 0; n++) @(negedge clk);
        check("sweep_drained", 32'(sb.size()), 0);
        check("sweep_handshakes", 32'(out_hs - hs0), 256);
        rand_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
